// File: rtl/dmb_rdout_pkg.sv
// Shared definitions for the DMB FIFO readout sequencer: FIFO numbering,
// bus layout and the sequencer state encoding.
package dmb_rdout_pkg;

    localparam int NFIFO      = 7;
    localparam int EOF_BIT    = 17;

    localparam int FIFO_CFEB1 = 1;
    localparam int FIFO_CFEB2 = 2;
    localparam int FIFO_CFEB3 = 3;
    localparam int FIFO_CFEB4 = 4;
    localparam int FIFO_CFEB5 = 5;
    localparam int FIFO_ALCT  = 6;
    localparam int FIFO_TMB   = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_OE,
        ST_READ,
        ST_GAP,
        ST_FIN
    } rd_state_t;

endpackage

// File: rtl/rdout_pick.sv
// Lowest-set-bit selector over the pending FIFO mask. The index is the
// 1-based FIFO number (matching FIFO_* constants); 0 when nothing is pending.
module rdout_pick
    import dmb_rdout_pkg::*;
(
    input  logic [6:0] mask,
    output logic [6:0] sel,
    output logic [2:0] idx,
    output logic       none
);

    always_comb begin
        sel  = '0;
        idx  = '0;
        none = 1'b1;
        // Scan downwards so the lowest set bit is the last one to win.
        for (int i = NFIFO - 1; i >= 0; i--) begin
            if (mask[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
                idx    = 3'(i + 1);
                none   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fifo_rdout_seq.sv
// Per-event readout sequencer for the seven DMB data FIFOs: visits each DAV
// FIFO in ascending order, streams it to DOUT until EOF, flags stalls/overruns.
module fifo_rdout_seq
    import dmb_rdout_pkg::*;
#(
    parameter int TMO_LIM = 255,
    parameter int MAXW    = 1024
) (
    input  logic        CLKDDU,
    input  logic        RST,
    input  logic        EVT_START,
    input  logic [6:0]  DAVMASK,
    input  logic [6:0]  FFOR_B,
    input  logic [17:0] DATAIN,
    input  logic        HOLD,
    output logic [6:0]  OEFIFO_B,
    output logic [6:0]  RENFIFO_B,
    output logic [15:0] DOUT,
    output logic        DOUT_VLD,
    output logic        DOUT_LAST,
    output logic        BUSY,
    output logic        DONE,
    output logic [6:0]  TMO,
    output logic [6:0]  TRUNC,
    output logic        OVLP
);

    localparam int TW = $clog2(TMO_LIM + 1);
    localparam int WW = $clog2(MAXW + 1);

    rd_state_t     state, state_nxt;
    logic [6:0]    pend, sel_oh, tmo_q, trunc_q, pk_oh;
    logic [2:0]    sel_idx, pk_idx;
    logic          pk_none;
    logic          rd_q, busy_q, done_q, ovlp_q, vld_q, last_q;
    logic [15:0]   dout_q;
    logic [TW-1:0] tcnt;
    logic [WW-1:0] wcnt;
    logic          in_read, rdy, cap, cap_eof, wlim, ren;
    logic          stall_inc, tmo_hit, trunc_hit;
    logic          unused_rsvd;

    rdout_pick u_pick (
        .mask (pend),
        .sel  (pk_oh),
        .idx  (pk_idx),
        .none (pk_none)
    );

    assign unused_rsvd = DATAIN[16];

    assign in_read = (state == ST_READ);
    assign rdy     = ~FFOR_B[sel_idx - 3'd1];
    assign cap     = in_read & rd_q;
    assign cap_eof = cap & DATAIN[EOF_BIT];
    // Words already captured plus the one in flight; never strobe past MAXW.
    assign wlim    = (int'(wcnt) + int'(rd_q)) >= MAXW;
    // EOF arriving on the bus this cycle suppresses the next strobe directly.
    assign ren     = in_read & rdy & ~HOLD & ~cap_eof & ~wlim;

    assign stall_inc = in_read & ~rdy & ~HOLD;
    assign tmo_hit   = stall_inc & (int'(tcnt) == TMO_LIM - 1);
    assign trunc_hit = cap & ~DATAIN[EOF_BIT] & ((int'(wcnt) + 1) >= MAXW);

    always_comb begin
        state_nxt = state;
        OEFIFO_B  = 7'h7F;
        RENFIFO_B = 7'h7F;
        case (state)
            ST_IDLE: if (EVT_START) state_nxt = ST_PICK;
            ST_PICK: state_nxt = pk_none ? ST_FIN : ST_OE;
            ST_OE: begin
                OEFIFO_B  = ~sel_oh;
                state_nxt = ST_READ;
            end
            ST_READ: begin
                OEFIFO_B = ~sel_oh;
                if (ren) RENFIFO_B = ~sel_oh;
                if (cap_eof || trunc_hit || tmo_hit) state_nxt = ST_GAP;
            end
            ST_GAP:  state_nxt = ST_PICK;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLKDDU) begin
        if (RST) begin
            state   <= ST_IDLE;
            pend    <= '0;
            sel_oh  <= '0;
            sel_idx <= '0;
            tcnt    <= '0;
            wcnt    <= '0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovlp_q  <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            dout_q  <= '0;
            tmo_q   <= '0;
            trunc_q <= '0;
        end else begin
            state  <= state_nxt;
            rd_q   <= ren;
            done_q <= (state == ST_FIN);
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            if (EVT_START && state != ST_IDLE) ovlp_q <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (EVT_START) begin
                        pend    <= DAVMASK;
                        tmo_q   <= '0;
                        trunc_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_PICK: begin
                    if (!pk_none) begin
                        pend    <= pend & ~pk_oh;
                        sel_oh  <= pk_oh;
                        sel_idx <= pk_idx;
                        tcnt    <= '0;
                        wcnt    <= '0;
                    end
                end
                ST_READ: begin
                    if (cap) begin
                        dout_q <= DATAIN[15:0];
                        vld_q  <= 1'b1;
                        last_q <= DATAIN[EOF_BIT];
                        if (int'(wcnt) < MAXW) wcnt <= wcnt + 1'b1;
                    end
                    if (ren)            tcnt <= '0;
                    else if (stall_inc) tcnt <= tcnt + 1'b1;
                    if (tmo_hit)   tmo_q   <= tmo_q | sel_oh;
                    if (trunc_hit) trunc_q <= trunc_q | sel_oh;
                end
                ST_FIN:  busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign DOUT      = dout_q;
    assign DOUT_VLD  = vld_q;
    assign DOUT_LAST = last_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign TMO       = tmo_q;
    assign TRUNC     = trunc_q;
    assign OVLP      = ovlp_q;

endmodule

// File: tb/tb_fifo_rdout_seq.sv
// Directed bench for fifo_rdout_seq: behavioural FIFOs, one linear stimulus
// sequence, immediate assertions against hand-derived values.
module tb_fifo_rdout_seq;

    logic        CLKDDU, RST, EVT_START, HOLD;
    logic [6:0]  DAVMASK, FFOR_B, OEFIFO_B, RENFIFO_B, TMO, TRUNC;
    logic [17:0] DATAIN;
    logic [15:0] DOUT;
    logic        DOUT_VLD, DOUT_LAST, BUSY, DONE, OVLP;

    fifo_rdout_seq #(.TMO_LIM(8), .MAXW(32)) u_dut (
        .CLKDDU(CLKDDU), .RST(RST), .EVT_START(EVT_START), .DAVMASK(DAVMASK),
        .FFOR_B(FFOR_B), .DATAIN(DATAIN), .HOLD(HOLD), .OEFIFO_B(OEFIFO_B),
        .RENFIFO_B(RENFIFO_B), .DOUT(DOUT), .DOUT_VLD(DOUT_VLD),
        .DOUT_LAST(DOUT_LAST), .BUSY(BUSY), .DONE(DONE), .TMO(TMO),
        .TRUNC(TRUNC), .OVLP(OVLP)
    );

    initial CLKDDU = 1'b0;
    always #5 CLKDDU = ~CLKDDU;

    logic [17:0] mem [7][64];
    int          ptr [7];
    int          len [7];
    int          stall_cnt [7];
    logic [15:0] got [64];
    int total, bad;
    int cyc, ngot, nlast, ndone, nstrobe, nhold_viol, nstrb_viol;
    int t_oe_first, t_ren, t_vld, t_done, t_oe2, t_oe7, n_at_oe7, hold_per, errs;

    localparam logic [48:0] RST_VEC = {7'h7F, 7'h7F, 16'h0, 5'b0, 7'h0, 7'h0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        cyc = 0; ngot = 0; nlast = 0; ndone = 0; nstrobe = 0;
        nhold_viol = 0; nstrb_viol = 0;
        t_oe_first = -1; t_ren = -1; t_vld = -1; t_done = -1;
        t_oe2 = -1; t_oe7 = -1; n_at_oe7 = -1;
    endtask

    task automatic load(input int f, input int n, input int eof_at, input logic [15:0] base);
        for (int k = 0; k < n; k++) mem[f][k] = {(k + 1 == eof_at), 1'b0, base + 16'(k)};
        len[f] = n;
        ptr[f] = 0;
    endtask

    // One clock: drive FIFO flags/HOLD, sample the cycle, then let the FIFOs pop.
    task automatic step();
        logic [6:0] pop;
        for (int i = 0; i < 7; i++) FFOR_B[i] = (stall_cnt[i] > 0) || (ptr[i] >= len[i]);
        if (hold_per > 0) HOLD = ((cyc / hold_per) % 2) == 1;
        #1;
        cyc++;
        if (DOUT_VLD) begin
            if (t_vld < 0) t_vld = cyc;
            if (ngot < 64) got[ngot] = DOUT;
            ngot++;
            if (DOUT_LAST) nlast++;
        end
        if (DONE) begin ndone++; t_done = cyc; end
        if (RENFIFO_B != 7'h7F || OEFIFO_B != 7'h7F) nstrobe++;
        if (HOLD && RENFIFO_B != 7'h7F) nhold_viol++;
        if ($countones(~OEFIFO_B) > 1 || $countones(~RENFIFO_B) > 1 ||
            (~RENFIFO_B & OEFIFO_B) != 7'h0) nstrb_viol++;
        if (OEFIFO_B != 7'h7F && t_oe_first < 0) t_oe_first = cyc;
        if (RENFIFO_B != 7'h7F && t_ren < 0) t_ren = cyc;
        if (!OEFIFO_B[1]) t_oe2 = cyc;
        if (!OEFIFO_B[6] && t_oe7 < 0) begin t_oe7 = cyc; n_at_oe7 = ngot; end
        pop = RENFIFO_B;
        for (int i = 0; i < 7; i++) if (stall_cnt[i] > 0) stall_cnt[i]--;
        @(posedge CLKDDU);
        #1;
        for (int i = 0; i < 7; i++) begin
            if (!pop[i] && ptr[i] < 64) begin
                DATAIN = mem[i][ptr[i]];
                ptr[i]++;
            end
        end
    endtask

    task automatic run_evt(input logic [6:0] mask, input string tag);
        clr_mon();
        DAVMASK = mask; EVT_START = 1'b1;
        step();
        EVT_START = 1'b0; DAVMASK = '0;
        for (int k = 0; k < 400 && ndone == 0; k++) step();
        chk({tag, "_done_seen"}, ndone, 1);
        step(); step();
        HOLD = 1'b0; hold_per = 0;
    endtask

    initial begin
        total = 0; bad = 0; hold_per = 0;
        RST = 1'b1; EVT_START = 1'b0; DAVMASK = '0; HOLD = 1'b0;
        FFOR_B = 7'h7F; DATAIN = '0;
        for (int i = 0; i < 7; i++) begin ptr[i] = 0; len[i] = 0; stall_cnt[i] = 0; end
        clr_mon();
        @(posedge CLKDDU); #1;
        step(); step(); step();
        RST = 1'b0;
        step();
        chk("reset_vec", {OEFIFO_B, RENFIFO_B, DOUT, DOUT_VLD, DOUT_LAST, BUSY, DONE, OVLP, TMO, TRUNC}, RST_VEC);

        // FIFO1, 4 words, EOF on the 4th
        load(0, 4, 4, 16'h1000);
        run_evt(7'b0000001, "t1");
        chk("t1_words", ngot, 4);
        chk("t1_last", nlast, 1);
        chk("t1_w0", got[0], 16'h1000);
        chk("t1_w3", got[3], 16'h1003);
        chk("t1_evt2oe", t_oe_first, 3);
        chk("t1_latency", t_vld - t_ren, 2);
        chk("t1_flags", {TMO, TRUNC, BUSY}, 15'h0);

        // empty mask
        run_evt(7'b0000000, "empty");
        chk("empty_done_at", t_done, 4);
        chk("empty_strobes", nstrobe, 0);

        // FIFO2 then FIFO7, 3 words each
        load(1, 3, 3, 16'h2000);
        load(6, 3, 3, 16'h7000);
        run_evt(7'b1000010, "t2");
        chk("t2_words", ngot, 6);
        chk("t2_last", nlast, 2);
        chk("t2_fifo2_first", n_at_oe7, 3);
        chk("t2_oe_spacing", t_oe7 - t_oe2, 3);
        chk("t2_w2", got[2], 16'h2002);
        chk("t2_w3", got[3], 16'h7000);
        chk("t2_w5", got[5], 16'h7002);
        chk("t2_strb_rules", nstrb_viol, 0);

        // FIFO1 never ready
        load(0, 2, 2, 16'h1100);
        stall_cnt[0] = 1000;
        run_evt(7'b0000001, "tmo");
        stall_cnt[0] = 0;
        chk("tmo_flag", TMO, 7'b0000001);
        chk("tmo_words", ngot, 0);
        chk("tmo_trunc", TRUNC, 7'h0);

        // 7 stalled READ cycles: one short of the limit
        load(0, 2, 2, 16'h1200);
        stall_cnt[0] = 10;
        run_evt(7'b0000001, "ntmo");
        chk("ntmo_flag", TMO, 7'h0);
        chk("ntmo_words", ngot, 2);

        // FIFO3 streams 40 words without EOF
        load(2, 40, 0, 16'h3000);
        run_evt(7'b0000100, "trunc");
        chk("trunc_words", ngot, 32);
        chk("trunc_flag", TRUNC, 7'b0000100);
        chk("trunc_last", nlast, 0);
        chk("trunc_w31", got[31], 16'h301F);
        chk("trunc_tmo", TMO, 7'h0);

        // 32 words with EOF on word 32 while HOLD toggles every 5 cycles
        load(4, 32, 32, 16'h5000);
        hold_per = 5;
        run_evt(7'b0010000, "hold");
        errs = 0;
        for (int k = 0; k < 32; k++) if (got[k] !== 16'h5000 + 16'(k)) errs++;
        chk("hold_words", ngot, 32);
        chk("hold_order", errs, 0);
        chk("hold_last", nlast, 1);
        chk("hold_no_strobe", nhold_viol, 0);
        chk("hold_flags", {TMO, TRUNC}, 14'h0);

        // second start while busy, then reset mid-READ
        load(0, 20, 0, 16'h1300);
        clr_mon();
        DAVMASK = 7'b0000001; EVT_START = 1'b1;
        step();
        EVT_START = 1'b0; DAVMASK = '0;
        step();
        EVT_START = 1'b1;
        step();
        EVT_START = 1'b0;
        step(); step(); step();
        chk("ovlp_set", OVLP, 1'b1);
        chk("ovlp_busy", BUSY, 1'b1);
        chk("ovlp_reading", RENFIFO_B, 7'b1111110);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst_mid_vec", {OEFIFO_B, RENFIFO_B, DOUT, DOUT_VLD, DOUT_LAST, BUSY, DONE, OVLP, TMO, TRUNC}, RST_VEC);
        clr_mon();
        for (int k = 0; k < 20; k++) step();
        chk("rst_no_done", ndone, 0);
        chk("rst_no_strobe", nstrobe, 0);
        chk("rst_no_words", ngot, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
